// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the shared-adder scheduler.
package add_sched_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam int W_DEF    = 16;
  localparam int NREQ_MAX = 8;

  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/adder_share_sched_if.sv
// Request/response bundle between the requesters and the shared-adder scheduler.
interface adder_share_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = 16,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_wide;
  logic [NREQ*2*W-1:0]   req_a;
  logic [NREQ*2*W-1:0]   req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*W-1:0]        rsp_sum;
  logic                  rsp_carry;

  modport slave (
    input  req_valid, req_wide, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport master (
    output req_valid, req_wide, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/add_w.sv
// W-bit combinational ripple-carry adder built from fulladder cells.
module add_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign carry = c[W];
endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used to build the ripple chain.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_share_sched.sv
// Round-robin scheduler time-sharing one W-bit adder; wide ops take a low then a high pass.
module adder_share_sched
  import add_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEF,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                reset,
  adder_share_sched_if.slave  bus
);
  localparam int DW = 2 * W;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, id_q;
  logic [DW-1:0]  a_q, b_q;
  logic           cin_q, wide_q;
  logic [W-1:0]   sum_lo, sum_hi;
  logic           c_lo, c_hi;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [DW-1:0]  sel_a, sel_b;
  logic           sel_cin, sel_wide;

  logic [W-1:0]   add_a, add_b, add_s;
  logic           add_ci, add_co;

  // Rotate the valid vector so the search always starts at rr_ptr.
  logic [2*NREQ-1:0] vv, vrot;
  assign vv   = {bus.req_valid, bus.req_valid};
  assign vrot = vv >> rr_ptr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && vrot[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    sel_a         = '0;
    sel_b         = '0;
    sel_cin       = 1'b0;
    sel_wide      = 1'b0;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a    = bus.req_a[i*DW +: DW];
        sel_b    = bus.req_b[i*DW +: DW];
        sel_cin  = bus.req_cin[i];
        sel_wide = bus.req_wide[i];
        bus.req_ready[i] = (state == IDLE) && gnt_vld && !reset;
      end
    end
  end

  // Single adder instance; the high pass chains through the latched low carry.
  assign add_a  = (state == HI) ? a_q[DW-1:W] : a_q[W-1:0];
  assign add_b  = (state == HI) ? b_q[DW-1:W] : b_q[W-1:0];
  assign add_ci = (state == HI) ? c_lo        : cin_q;

  add_w #(.W(W)) u_add (
    .a     (add_a),
    .b     (add_b),
    .cin   (add_ci),
    .sum   (add_s),
    .carry (add_co)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_vld) state_nx = LO;
      LO:      state_nx = wide_q ? HI : RESP;
      HI:      state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      wide_q <= 1'b0;
      sum_lo <= '0;
      sum_hi <= '0;
      c_lo   <= 1'b0;
      c_hi   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          a_q    <= sel_a;
          b_q    <= sel_b;
          cin_q  <= sel_cin;
          wide_q <= sel_wide;
          id_q   <= gnt_id;
        end
        LO: begin
          sum_lo <= add_s;
          c_lo   <= add_co;
        end
        HI: begin
          sum_hi <= add_s;
          c_hi   <= add_co;
        end
        RESP: if (bus.rsp_ready) rr_ptr <= IDW'(next_rr(int'(id_q), NREQ));
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = wide_q ? {sum_hi, sum_lo} : {{W{1'b0}}, sum_lo};
  assign bus.rsp_carry = wide_q ? c_hi : c_lo;
endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: directed scenarios plus a random run against an A+B+cin queue model.
module tb_adder_share_sched;
  localparam int NREQ = 2;
  localparam int W    = 16;
  localparam int IDW  = 3;
  localparam int DW   = 2 * W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_share_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  adder_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: whatever was accepted must come back as the exact sum, in order.
  typedef struct {
    int            id;
    logic [DW-1:0] sum;
    logic          carry;
  } exp_t;

  exp_t expq[$];
  int   wait_cnt[NREQ];
  int   grants[NREQ];
  int   accepts = 0;

  function automatic exp_t model(input int i);
    exp_t          e;
    logic [DW-1:0] a, b;
    logic [DW:0]   t;
    logic [W:0]    tn;
    a = bus.req_a[i*DW +: DW];
    b = bus.req_b[i*DW +: DW];
    e.id = i;
    if (bus.req_wide[i]) begin
      t = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, bus.req_cin[i]};
      e.sum   = t[DW-1:0];
      e.carry = t[DW];
    end else begin
      tn = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]} + {{W{1'b0}}, bus.req_cin[i]};
      e.sum   = {{W{1'b0}}, tn[W-1:0]};
      e.carry = tn[W];
    end
    return e;
  endfunction

  logic           pv = 1'b0;
  logic [IDW-1:0] pid;
  logic [DW-1:0]  psum;
  logic           pcar;
  exp_t           me;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      pv = 1'b0;
      chk("ready_in_reset", bus.req_ready, 0);
    end else begin
      if (pv) begin
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_id",    bus.rsp_id, pid);
        chk("hold_sum",   bus.rsp_sum, psum);
        chk("hold_carry", bus.rsp_carry, pcar);
      end
      if (bus.req_ready != '0) begin
        chk("ready_onehot",    $onehot(bus.req_ready), 1);
        chk("ready_has_valid", bus.req_ready & ~bus.req_valid, 0);
        chk("ready_during_rsp", bus.rsp_valid, 0);
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_ready[i]) begin
            expq.push_back(model(i));
            grants[i]++;
            accepts++;
            wait_cnt[i] = 0;
          end else if (bus.req_valid[i]) begin
            wait_cnt[i]++;
            chk("starvation_bound", wait_cnt[i] <= NREQ - 1, 1);
          end else begin
            wait_cnt[i] = 0;
          end
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (expq.size() == 0) chk("rsp_without_accept", expq.size(), 1);
        else begin
          me = expq.pop_front();
          chk("model_id",    bus.rsp_id, me.id);
          chk("model_sum",   bus.rsp_sum, me.sum);
          chk("model_carry", bus.rsp_carry, me.carry);
        end
      end
      pv   = bus.rsp_valid && !bus.rsp_ready;
      pid  = bus.rsp_id;
      psum = bus.rsp_sum;
      pcar = bus.rsp_carry;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit wide, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit cin);
    bus.req_wide[i]        = wide;
    bus.req_a[i*DW +: DW]  = a;
    bus.req_b[i*DW +: DW]  = b;
    bus.req_cin[i]         = cin;
  endtask

  // Returns just after the accept edge, with that requester's valid dropped.
  task automatic wait_accept(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", ok, 1);
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen; lat counts edges from accept.
  task automatic wait_rsp(output int lat);
    bit ok = 1'b0;
    lat = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      lat++;
    end
    chk("rsp_timeout", ok, 1);
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h0000_FFFF;
      default: return DW'($urandom());
    endcase
  endfunction

  int          lat;
  logic [NREQ-1:0] acc;
  int          start;

  initial begin
    bus.req_valid = '1;
    bus.req_wide  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with requests pending to show nothing is granted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_id",    bus.rsp_id, 0);
      chk("rst_sum",   bus.rsp_sum, 0);
      chk("rst_carry", bus.rsp_carry, 0);
    end
    tick();
    bus.req_valid = '0;
    reset = 1'b0;
    tick();

    // Narrow, upper operand bits ignored, payload scrambled after accept.
    set_req(0, 0, 32'hABCD_FFFF, 32'h0000_0001, 0);
    bus.req_valid[0] = 1'b1;
    wait_accept(0);
    set_req(0, 1, 32'h1357_9BDF, 32'h2468_ACE0, 1);
    wait_rsp(lat);
    chk("t1_lat", lat, 2);
    chk("t1_sum", bus.rsp_sum, 32'h0000_0000);
    chk("t1_carry", bus.rsp_carry, 1);
    chk("t1_id", bus.rsp_id, 0);
    tick();
    @(negedge clk);
    chk("t1_idle", bus.rsp_valid, 0);
    tick();

    // Wide: carry crosses the halves.
    set_req(1, 1, 32'h0000_FFFF, 32'h0000_0001, 0);
    bus.req_valid[1] = 1'b1;
    wait_accept(1);
    wait_rsp(lat);
    chk("t2_lat", lat, 3);
    chk("t2_sum", bus.rsp_sum, 32'h0001_0000);
    chk("t2_carry", bus.rsp_carry, 0);
    chk("t2_id", bus.rsp_id, 1);
    tick();
    set_req(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    bus.req_valid[1] = 1'b1;
    wait_accept(1);
    wait_rsp(lat);
    chk("t2b_sum", bus.rsp_sum, 32'hFFFF_FFFF);
    chk("t2b_carry", bus.rsp_carry, 1);
    tick();

    // Fairness: pointer wrapped to 0, both valid continuously.
    set_req(0, 0, 32'h0000_1234, 32'h0000_1111, 0);
    set_req(1, 1, 32'h8000_0000, 32'h8000_0000, 0);
    bus.req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(lat);
      chk("t3_id", bus.rsp_id, k % 2);
      chk("t3_sum", bus.rsp_sum, (k % 2) ? 32'h0000_0000 : 32'h0000_2345);
      tick();
    end
    bus.req_valid = '0;
    tick();

    // Backpressure: response held, no grants while the other requester waits.
    bus.rsp_ready = 1'b0;
    set_req(0, 0, 32'h0000_00FF, 32'h0000_0F01, 1);
    set_req(1, 0, 32'h0000_0002, 32'h0000_0003, 0);
    bus.req_valid = '1;
    wait_accept(0);
    wait_rsp(lat);
    repeat (5) begin
      @(negedge clk);
      chk("t4_valid", bus.rsp_valid, 1);
      chk("t4_sum", bus.rsp_sum, 32'h0000_1001);
      chk("t4_id", bus.rsp_id, 0);
      chk("t4_noready", bus.req_ready, 0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t4_idle", bus.rsp_valid, 0);
    chk("t4_next_grant", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    chk("t4_id1", bus.rsp_id, 1);
    chk("t4_sum1", bus.rsp_sum, 32'h0000_0005);
    tick();

    // Reset during the high pass discards the op and rewinds the pointer.
    set_req(1, 1, 32'h1234_5678, 32'h1111_1111, 0);
    bus.req_valid[1] = 1'b1;
    wait_accept(1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = '1;
    @(negedge clk);
    chk("t5_no_rsp", bus.rsp_valid, 0);
    chk("t5_grant0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    chk("t5_id", bus.rsp_id, 0);
    chk("t5_sum", bus.rsp_sum, 32'h0000_1001);
    tick();

    // Random mix with backpressure and withdrawn requests.
    for (int i = 0; i < NREQ; i++) grants[i] = 0;
    start = accepts;
    for (int cyc = 0; cyc < 30000 && accepts - start < 2000; cyc++) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) bus.req_valid[i] = 1'b0;
        else if (bus.req_valid[i] && $urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(2) != 0) begin
          set_req(i, 1'($urandom_range(1)), rnd_op(), rnd_op(), 1'($urandom_range(1)));
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();
    chk("t6_ops_done", accepts - start >= 2000, 1);
    chk("t6_drained", expq.size(), 0);
    for (int i = 0; i < NREQ; i++) chk("t6_served", grants[i] > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
